// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants, opcodes and state type for the instruction fetch unit.
// Optional issue counter is enabled by INSTRUCTION_COUNTER_EN.
package fetch_unit_pkg;

  localparam int INSTRUCTION_WIDTH = 16;

  localparam logic [INSTRUCTION_WIDTH-1:0] HALT_INSTRUCTION = 16'hFFFF;
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION  = 16'h9000;

  localparam logic [3:0] ADD_OPCODE  = 4'b0000;
  localparam logic [3:0] LOAD_OPCODE = 4'b0001;
  localparam logic [3:0] JUMP_OPCODE = 4'b1000;
  localparam logic [3:0] NOP_OPCODE  = 4'b1001;
  localparam logic [3:0] HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(
    input logic [INSTRUCTION_WIDTH-1:0] word
  );
    return word == HALT_INSTRUCTION;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Host load / cpu issue bus of the fetch unit.
// issued_count_out exists only with INSTRUCTION_COUNTER_EN.
interface instruction_fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10
) ();

  logic                         load_enable_in;
  logic [ADDRESS_WIDTH-1:0]     load_address_in;
  logic [INSTRUCTION_WIDTH-1:0] load_data_in;
  logic                         start_in;
  logic                         stall_in;
  logic [INSTRUCTION_WIDTH-1:0] current_instruction_out;
  logic                         instruction_valid_out;
  logic [ADDRESS_WIDTH-1:0]     program_counter_out;
  logic                         busy_out;
  logic                         done_out;
`ifdef INSTRUCTION_COUNTER_EN
  logic [15:0]                  issued_count_out;
`endif

  modport master (
    output load_enable_in,
    output load_address_in,
    output load_data_in,
    output start_in,
    output stall_in,
    input  current_instruction_out,
    input  instruction_valid_out,
    input  program_counter_out,
    input  busy_out,
`ifdef INSTRUCTION_COUNTER_EN
    input  issued_count_out,
`endif
    input  done_out
  );

  modport slave (
    input  load_enable_in,
    input  load_address_in,
    input  load_data_in,
    input  start_in,
    input  stall_in,
    output current_instruction_out,
    output instruction_valid_out,
    output program_counter_out,
    output busy_out,
`ifdef INSTRUCTION_COUNTER_EN
    output issued_count_out,
`endif
    output done_out
  );

endinterface

// File: rtl/instruction_fetch_unit_memory.sv
// Program store: one write port, one synchronous read port, no reset.
// Read data appears one clock after the address is presented.
module instruction_memory #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             write_enable,
  input  logic [AW-1:0]    write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    read_address,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_enable)
      mem[write_address] <= write_data;
    read_data <= mem[read_address];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program store and sequencer feeding one instruction per clock to the cpu.
// Define INSTRUCTION_COUNTER_EN to add the saturating issue counter.
module instruction_fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int MEMORY_DEPTH  = 1024,
  parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
  input logic clock_in,
  input logic reset_in,
  instruction_fetch_unit_if.slave bus
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS =
    ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  fetch_state_t state;

  logic [ADDRESS_WIDTH-1:0]     fetch_address;
  logic [ADDRESS_WIDTH-1:0]     read_address;
  logic [INSTRUCTION_WIDTH-1:0] read_data;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [ADDRESS_WIDTH-1:0]     program_counter;
  logic                         valid;
  logic                         last_issued;
  logic                         loadable;
  logic                         start_go;
  logic                         issue;
  logic                         halt_now;

  assign loadable = (state == IDLE) || (state == HALTED);
  assign start_go = loadable && bus.start_in;

  assign issue = (state == RUN) && !last_issued
              && !bus.stall_in && !is_halt(read_data);

  // Once the top word has gone out, stop even if stalled: nothing remains.
  assign halt_now = (state == RUN)
                 && (last_issued
                     || (!bus.stall_in && is_halt(read_data)));

  always_comb begin
    read_address = fetch_address;
    if (start_go)
      read_address = '0;
    else if (issue)
      read_address = fetch_address + 1'b1;
  end

  instruction_memory #(
    .DEPTH (MEMORY_DEPTH),
    .WIDTH (INSTRUCTION_WIDTH),
    .AW    (ADDRESS_WIDTH)
  ) u_memory (
    .clk           (clock_in),
    .write_enable  (bus.load_enable_in && loadable),
    .write_address (bus.load_address_in),
    .write_data    (bus.load_data_in),
    .read_address  (read_address),
    .read_data     (read_data)
  );

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state           <= IDLE;
      fetch_address   <= '0;
      program_counter <= '0;
      instruction     <= NOP_INSTRUCTION;
      valid           <= 1'b0;
      last_issued     <= 1'b0;
    end else begin
      valid <= issue;
      unique case (state)
        IDLE, HALTED: begin
          if (start_go) begin
            state         <= PRIME;
            fetch_address <= '0;
            last_issued   <= 1'b0;
          end
        end
        PRIME: state <= RUN;
        RUN: begin
          if (issue) begin
            instruction     <= read_data;
            program_counter <= fetch_address;
            fetch_address   <= fetch_address + 1'b1;
            last_issued     <= fetch_address == LAST_ADDRESS;
          end
          if (halt_now) begin
            state       <= HALTED;
            instruction <= NOP_INSTRUCTION;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSTRUCTION_COUNTER_EN
  logic [15:0] issued_count;

  always_ff @(posedge clock_in) begin
    if (reset_in || start_go)
      issued_count <= '0;
    else if (valid && issued_count != 16'hFFFF)
      issued_count <= issued_count + 16'd1;
  end

  assign bus.issued_count_out = issued_count;
`endif

  assign bus.current_instruction_out = instruction;
  assign bus.instruction_valid_out   = valid;
  assign bus.program_counter_out     = program_counter;
  assign bus.busy_out = (state == PRIME) || (state == RUN);
  assign bus.done_out = state == HALTED;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an 8-word program store.
module tb_instruction_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDRESS_WIDTH(AW)) bus ();

  instruction_fetch_unit #(
    .MEMORY_DEPTH  (DEPTH),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] ins,
                            input logic vld, input logic [AW-1:0] pc);
    check({tag, ".ins"}, 32'(bus.current_instruction_out), 32'(ins));
    check({tag, ".vld"}, 32'(bus.instruction_valid_out), 32'(vld));
    check({tag, ".pc"}, 32'(bus.program_counter_out), 32'(pc));
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
    bus.load_enable_in  = 1'b1;
    bus.load_address_in = a;
    bus.load_data_in    = d;
    tick();
    bus.load_enable_in  = 1'b0;
  endtask

  // Start pulse, PRIME cycle; returns right after the first issue edge.
  task automatic start_run();
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.load_enable_in  = 1'b0;
    bus.load_address_in = '0;
    bus.load_data_in    = '0;
    bus.start_in        = 1'b0;
    bus.stall_in        = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    expect_out("reset", 16'h9000, 1'b0, 3'd0);
    check("reset.busy", 32'(bus.busy_out), 32'd0);
    check("reset.done", 32'(bus.done_out), 32'd0);

    load(3'd0, 16'h0123);
    load(3'd1, 16'hA201);
    load(3'd2, 16'h9000);
    load(3'd3, 16'hFFFF);
    check("idle.busy", 32'(bus.busy_out), 32'd0);

    // basic stream
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    check("prime.busy", 32'(bus.busy_out), 32'd1);
    check("prime.vld", 32'(bus.instruction_valid_out), 32'd0);
    tick();
    check("run0.vld", 32'(bus.instruction_valid_out), 32'd0);
    tick();
    expect_out("basic0", 16'h0123, 1'b1, 3'd0);
    tick();
    expect_out("basic1", 16'hA201, 1'b1, 3'd1);
    tick();
    expect_out("basic2", 16'h9000, 1'b1, 3'd2);
    tick();
    expect_out("basic_halt", 16'h9000, 1'b0, 3'd2);
    check("basic.done", 32'(bus.done_out), 32'd1);
    check("basic.busy", 32'(bus.busy_out), 32'd0);
    tick();
    expect_out("basic_hold", 16'h9000, 1'b0, 3'd2);

    // stall for three cycles with A201 pending
    start_run();
    expect_out("stall0", 16'h0123, 1'b1, 3'd0);
    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall_hold%0d", i), 16'h0123, 1'b0, 3'd0);
    end
    bus.stall_in = 1'b0;
    tick();
    expect_out("stall1", 16'hA201, 1'b1, 3'd1);
    tick();
    expect_out("stall2", 16'h9000, 1'b1, 3'd2);
    tick();
    check("stall.done", 32'(bus.done_out), 32'd1);
`ifdef INSTRUCTION_COUNTER_EN
    check("count.halted", 32'(bus.issued_count_out), 32'd3);
    tick();
    check("count.hold", 32'(bus.issued_count_out), 32'd3);
    bus.start_in = 1'b1;
    tick();
    bus.start_in = 1'b0;
    check("count.clear", 32'(bus.issued_count_out), 32'd0);
    tick();
    tick();
    tick();
    tick();
    tick();
`endif

    // load attempted while running
    start_run();
    expect_out("blk0", 16'h0123, 1'b1, 3'd0);
    bus.load_enable_in  = 1'b1;
    bus.load_address_in = 3'd2;
    bus.load_data_in    = 16'h7777;
    tick();
    expect_out("blk1", 16'hA201, 1'b1, 3'd1);
    tick();
    bus.load_enable_in = 1'b0;
    expect_out("blk2", 16'h9000, 1'b1, 3'd2);
    tick();
    check("blk.done", 32'(bus.done_out), 32'd1);
    start_run();
    tick();
    tick();
    expect_out("blk_rerun2", 16'h9000, 1'b1, 3'd2);
    tick();

    // reset on the second issue
    start_run();
    tick();
    expect_out("rst_mid1", 16'hA201, 1'b1, 3'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst_mid", 16'h9000, 1'b0, 3'd0);
    check("rst_mid.busy", 32'(bus.busy_out), 32'd0);
    check("rst_mid.done", 32'(bus.done_out), 32'd0);
    start_run();
    expect_out("rst_rerun0", 16'h0123, 1'b1, 3'd0);
    tick();
    tick();
    tick();
    check("rst_rerun.done", 32'(bus.done_out), 32'd1);

    // end of memory without a HALT word
    for (int i = 0; i < DEPTH; i++)
      load(AW'(i), 16'h1111);
    start_run();
    for (int i = 0; i < DEPTH; i++) begin
      expect_out($sformatf("eom%0d", i), 16'h1111, 1'b1, AW'(i));
      if (i < DEPTH - 1)
        tick();
    end
    tick();
    expect_out("eom_halt", 16'h9000, 1'b0, 3'd7);
    check("eom.done", 32'(bus.done_out), 32'd1);
    tick();
    expect_out("eom_nowrap", 16'h9000, 1'b0, 3'd7);

    // load and start in the same cycle
    bus.load_enable_in  = 1'b1;
    bus.load_address_in = 3'd0;
    bus.load_data_in    = 16'h0ABC;
    bus.start_in        = 1'b1;
    tick();
    bus.load_enable_in = 1'b0;
    bus.start_in       = 1'b0;
    tick();
    tick();
    expect_out("ldst0", 16'h0ABC, 1'b1, 3'd0);
    tick();
    expect_out("ldst1", 16'h1111, 1'b1, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
